// File: rtl/pc_redirect_if.sv
// pc_redirect_if: execute-stage inputs and fetch-side outputs of pc_redirect_unit
interface pc_redirect_if;
    logic [31:0] Instruction, ex_pc, rs1Data, pc;
    logic ex_valid, Branch, stall, imem_ready;
    logic imem_req, redirect, flush, misalign;
    modport master(
        output Instruction, ex_pc, ex_valid, rs1Data, Branch, stall, imem_ready,
        input  pc, imem_req, redirect, flush, misalign
    );
    modport slave(
        input  Instruction, ex_pc, ex_valid, rs1Data, Branch, stall, imem_ready,
        output pc, imem_req, redirect, flush, misalign
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC stepping, branch/JAL/JALR redirect and multi-cycle flush.
// Optional PC_MISALIGN_TRAP_EN sends targets with bit 1 set to TRAP_VEC.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
    parameter int          FLUSH_CYCLES = 2
) (
    input logic         clk,
    input logic         rst,
    pc_redirect_if.slave bus
);
    typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;
    state_t state, state_n;
    logic [31:0] ins, pc_q, pc_n, b_imm, j_imm, i_imm, target, dest;
    logic [2:0] cnt, cnt_n;
    logic sb, jal, jalr, taken, step, bad, redirect_q, misalign_q;
    assign ins   = bus.Instruction;
    assign sb    = ins[6:0] == 7'b1100011;
    assign jal   = ins[6:0] == 7'b1101111;
    assign jalr  = ins[6:0] == 7'b1100111;
    assign b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign i_imm = {{20{ins[31]}}, ins[31:20]};
    assign target = jalr ? (bus.rs1Data + i_imm) & ~32'h1
                         : bus.ex_pc + (jal ? j_imm : b_imm);
    assign taken = state == FETCH && bus.ex_valid && ((sb && bus.Branch) || jal || jalr);
    assign step  = bus.imem_ready && !bus.stall;
`ifdef PC_MISALIGN_TRAP_EN
    assign bad  = target[1];
    assign dest = bad ? TRAP_VEC : target;
`else
    logic unused_trap;
    assign unused_trap = ^TRAP_VEC;
    assign bad  = 1'b0;
    assign dest = target;
`endif
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        cnt_n   = cnt;
        case (state)
            BOOT: state_n = FETCH;
            FETCH: begin
                if (taken) begin
                    pc_n    = dest;
                    cnt_n   = 3'(FLUSH_CYCLES - 1);
                    state_n = FLUSH_CYCLES == 1 ? FETCH : FLUSH;
                end else if (step) begin
                    pc_n = pc_q + 32'd4;
                end
            end
            default: begin
                pc_n    = step ? pc_q + 32'd4 : pc_q;
                cnt_n   = cnt - 3'd1;
                state_n = cnt == 3'd0 ? FETCH : FLUSH;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc_q       <= RESET_PC;
            cnt        <= 3'd0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_n;
            pc_q       <= pc_n;
            cnt        <= cnt_n;
            redirect_q <= taken;
            misalign_q <= taken && bad;
        end
    end
    // A single-cycle flush never leaves FETCH, so the redirect pulse covers it
    assign bus.pc       = pc_q;
    assign bus.imem_req = state != BOOT;
    assign bus.redirect = redirect_q;
    assign bus.flush    = redirect_q || state == FLUSH;
    assign bus.misalign = misalign_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: table-driven cycle vectors checked through an expectation queue,
// plus a bounded flush-length sequence.
module tb_pc_redirect_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    pc_redirect_if bus();
    pc_redirect_unit dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BEQ  = 32'h0000_0463;
    localparam logic [31:0] JAL  = 32'hFFDF_F06F;
    localparam logic [31:0] JALR = 32'h0000_8067;

    typedef struct {
        logic        r;
        logic [31:0] ins, expc, rs1;
        logic        exv, br, st, rdy;
        logic [31:0] pc;
        logic        req, red, fl, mis;
    } vec_t;

    vec_t tbl[31];
    vec_t q[$];
    int total = 0;
    int passed = 0;

    function automatic vec_t v(input logic r, input logic [31:0] ins, expc, rs1,
                               input logic exv, br, st, rdy, input logic [31:0] pc,
                               input logic req, red, fl, mis);
        vec_t x;
        x = '{r, ins, expc, rs1, exv, br, st, rdy, pc, req, red, fl, mis};
        return x;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic apply(input vec_t x);
        rst             = x.r;
        bus.Instruction = x.ins;
        bus.ex_pc       = x.expc;
        bus.rs1Data     = x.rs1;
        bus.ex_valid    = x.exv;
        bus.Branch      = x.br;
        bus.stall       = x.st;
        bus.imem_ready  = x.rdy;
        q.push_back(x);
    endtask

    task automatic check(input int i);
        vec_t e;
        if (q.size() == 0) begin
            cmp($sformatf("r%0d queue", i), 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        cmp($sformatf("r%0d pc", i), bus.pc, e.pc);
        cmp($sformatf("r%0d imem_req", i), 32'(bus.imem_req), 32'(e.req));
        cmp($sformatf("r%0d redirect", i), 32'(bus.redirect), 32'(e.red));
        cmp($sformatf("r%0d flush", i), 32'(bus.flush), 32'(e.fl));
        cmp($sformatf("r%0d misalign", i), 32'(bus.misalign), 32'(e.mis));
    endtask

    initial begin
        int n;
        bus.Instruction = NOP; bus.ex_pc = 0; bus.rs1Data = 0; bus.ex_valid = 0;
        bus.Branch = 0; bus.stall = 0; bus.imem_ready = 0;
        //            r  ins   ex_pc   rs1            exv br st rdy  pc            req red fl mis
        tbl[0]  = v(1, NOP,  32'h0,   32'h0,         0, 0, 0, 0, 32'h0,          0, 0, 0, 0);
        tbl[1]  = v(1, NOP,  32'h0,   32'h0,         0, 0, 0, 0, 32'h0,          0, 0, 0, 0);
        tbl[2]  = v(1, NOP,  32'h0,   32'h0,         0, 0, 0, 1, 32'h0,          0, 0, 0, 0);
        tbl[3]  = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 1, 32'h0,          1, 0, 0, 0);
        tbl[4]  = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 1, 32'h4,          1, 0, 0, 0);
        tbl[5]  = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 1, 32'h8,          1, 0, 0, 0);
        tbl[6]  = v(0, BEQ,  32'h100, 32'h0,         1, 1, 0, 1, 32'h108,        1, 1, 1, 0);
        tbl[7]  = v(0, BEQ,  32'h100, 32'h0,         1, 1, 0, 0, 32'h108,        1, 0, 1, 0);
        tbl[8]  = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 0, 32'h108,        1, 0, 0, 0);
        tbl[9]  = v(0, JAL,  32'h10,  32'h0,         1, 0, 1, 1, 32'hC,          1, 1, 1, 0);
        tbl[10] = v(0, NOP,  32'h0,   32'h0,         0, 0, 1, 1, 32'hC,          1, 0, 1, 0);
        tbl[11] = v(0, NOP,  32'h0,   32'h0,         0, 0, 1, 1, 32'hC,          1, 0, 0, 0);
        tbl[12] = v(0, JALR, 32'h0,   32'h40,        1, 0, 0, 0, 32'h40,         1, 1, 1, 0);
        tbl[13] = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 0, 32'h40,         1, 0, 1, 0);
        tbl[14] = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 0, 32'h40,         1, 0, 0, 0);
        tbl[15] = v(0, BEQ,  32'h100, 32'h0,         1, 0, 0, 1, 32'h44,         1, 0, 0, 0);
        tbl[16] = v(0, BEQ,  32'h100, 32'h0,         0, 1, 0, 1, 32'h48,         1, 0, 0, 0);
        tbl[17] = v(0, JALR, 32'h0,   32'h203,       1, 0, 0, 1, TRAP ? 32'h100 : 32'h202, 1, 1, 1, TRAP);
        tbl[18] = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 0, TRAP ? 32'h100 : 32'h202, 1, 0, 1, 0);
        tbl[19] = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 0, TRAP ? 32'h100 : 32'h202, 1, 0, 0, 0);
        tbl[20] = v(0, JALR, 32'h0,   32'hFFFF_FFFC, 1, 0, 0, 0, 32'hFFFF_FFFC,  1, 1, 1, 0);
        tbl[21] = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 0, 32'hFFFF_FFFC,  1, 0, 1, 0);
        tbl[22] = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 0, 32'hFFFF_FFFC,  1, 0, 0, 0);
        tbl[23] = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 1, 32'h0,          1, 0, 0, 0);
        tbl[24] = v(0, JAL,  32'h10,  32'h0,         1, 0, 0, 1, 32'hC,          1, 1, 1, 0);
        tbl[25] = v(1, NOP,  32'h0,   32'h0,         0, 0, 0, 1, 32'h0,          0, 0, 0, 0);
        tbl[26] = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 1, 32'h0,          1, 0, 0, 0);
        tbl[27] = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 1, 32'h4,          1, 0, 0, 0);
        tbl[28] = v(0, JAL,  32'h10,  32'h0,         1, 0, 0, 1, 32'hC,          1, 1, 1, 0);
        tbl[29] = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 1, 32'h10,         1, 0, 1, 0);
        tbl[30] = v(0, NOP,  32'h0,   32'h0,         0, 0, 0, 1, 32'h14,         1, 0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 31; i++) begin
            apply(tbl[i]);
            @(posedge clk);
            #1;
            check(i);
        end
        // JALR taken then count how long flush stays high, bounded
        bus.Instruction = JALR; bus.rs1Data = 32'h80; bus.ex_valid = 1; bus.imem_ready = 0;
        @(posedge clk);
        #1;
        cmp("seq jalr pc", bus.pc, 32'h80);
        cmp("seq jalr redirect", 32'(bus.redirect), 32'd1);
        bus.ex_valid = 0;
        n = 0;
        while (bus.flush && n < 10) begin
            n++;
            @(posedge clk);
            #1;
        end
        cmp("seq flush_len", n, 2);
        cmp("seq pc hold", bus.pc, 32'h80);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
